// File: rtl/wb_bridge_pkg.sv
// Shared types and sizing helpers for the core-to-Wishbone master bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

  // One spare bit so the timer can never wrap before it expires.
  function automatic int unsigned timer_width(input int unsigned timeout_cycles);
    return 32'($clog2(timeout_cycles)) + 32'd1;
  endfunction

  localparam int unsigned TIMER_W_DEF = timer_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter that flags the last permitted bus cycle before an abort.
module wb_timeout_counter
  import wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned    CNT_W   = timer_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic           ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && ENABLED) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = ENABLED && (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Turns valid/ready core load/store requests into single Wishbone classic
// cycles, one outstanding at a time, with an optional no-ack timeout.
module wb_master_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ack_i
);

  state_e                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  busy_q, busy_d;

  logic timer_clear_c;
  logic timer_en_c;
  logic timer_expired_c;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (timer_clear_c),
    .enable    (timer_en_c),
    .expired_c (timer_expired_c)
  );

  // Next-state and registered-output logic; an ack always beats the timeout.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    we_d          = we_q;
    addr_d        = addr_q;
    data_d        = data_q;
    resp_valid_d  = resp_valid_q;
    resp_err_d    = resp_err_q;
    resp_rdata_d  = resp_rdata_q;
    timer_clear_c = 1'b0;
    timer_en_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d          = req_we;
          addr_d        = req_addr;
          data_d        = req_wdata;
          cyc_d         = 1'b1;
          stb_d         = 1'b1;
          timer_clear_c = 1'b1;
          state_d       = BUS;
        end
      end
      BUS: begin
        if (ack_i) begin
          resp_rdata_d = we_q ? '0 : data_i;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          state_d      = RESP;
        end else if (timer_expired_c) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          state_d      = RESP;
        end else begin
          timer_en_c = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign busy       = busy_q;
  assign cyc_o      = cyc_q;
  assign stb_o      = stb_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;

endmodule
